// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer between the per-cache request
// ports and the single cache-memory bus controller, with a BUSY watchdog.
module cache_bus_arbiter #(
   parameter int CONNECTIONS = 2,
   parameter int ADDR_WIDTH  = 64,
   parameter int TIMEOUT     = 1024
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [CONNECTIONS-1:0]            req_valid,
   input  logic [CONNECTIONS-1:0]            req_store,
   input  logic [CONNECTIONS*ADDR_WIDTH-1:0] req_addr,
   output logic [CONNECTIONS-1:0]            req_ready,
   input  logic                              snoop_busy,
   output logic                              grant_valid,
   input  logic                              grant_ready,
   output logic [$clog2(CONNECTIONS)-1:0]    grant_id,
   output logic                              grant_store,
   output logic [ADDR_WIDTH-1:0]             grant_addr,
   input  logic                              done,
   output logic                              busy,
   output logic                              timeout_err
);

   localparam int IDW = $clog2(CONNECTIONS);
   localparam int WDW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   state_t         state;
   logic [IDW-1:0] last_id;
   logic [WDW-1:0] watchdog;
   logic [IDW-1:0] winner;
   logic           found;
   logic           accept;

   // Search begins one past the last completed requester and wraps modulo CONNECTIONS.
   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned i = 0; i < CONNECTIONS; i++) begin
         idx = (32'(last_id) + 1 + i) % CONNECTIONS;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   assign accept    = (state == IDLE) && !snoop_busy && found && !reset;
   assign req_ready = accept ? (CONNECTIONS'(1) << winner) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant_valid <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         grant_id    <= '0;
         grant_store <= 1'b0;
         grant_addr  <= '0;
         last_id     <= IDW'(CONNECTIONS - 1);
         watchdog    <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  grant_id    <= winner;
                  grant_store <= req_store[winner];
                  grant_addr  <= req_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                  grant_valid <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (grant_ready) begin
                  grant_valid <= 1'b0;
                  if (done) begin
                     busy    <= 1'b0;
                     last_id <= grant_id;
                     state   <= IDLE;
                  end else begin
                     watchdog <= '0;
                     state    <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (done) begin
                  busy    <= 1'b0;
                  last_id <= grant_id;
                  state   <= IDLE;
               end else if (watchdog == WDW'(TIMEOUT - 1)) begin
                  busy        <= 1'b0;
                  timeout_err <= 1'b1;
                  last_id     <= grant_id;
                  state       <= IDLE;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            default: begin
               grant_valid <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Round-robin arbiter and transaction sequencer placed between the per-cache request ports (I-cache, D-cache, …) and the single AXI cache-memory bus controller. Each cycle in which it is free, it selects one pending cache request, captures its address and direction, and presents exactly one transaction downstream. It holds that grant until the bus controller reports completion. It stalls new grants while a snoop is in progress and recovers from a hung transaction with a watchdog.

## Interface
Parameters:
- CONNECTIONS, 2, number of requesting caches (2..8)
- ADDR_WIDTH, 64, request address width
- TIMEOUT, 1024, max cycles in BUSY before abort (≥4)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  CONNECTIONS  per-cache request pending
- req_store  in  CONNECTIONS  per-cache direction: 1 = writeback, 0 = line fill
- req_addr  in  CONNECTIONS×ADDR_WIDTH  per-cache line address
- req_ready  out  CONNECTIONS  one-hot accept pulse to the selected cache
- snoop_busy  in  1  bus controller is servicing an AC snoop; blocks new grants
- grant_valid  out  1  transaction presented downstream
- grant_ready  in  1  downstream accepts transaction
- grant_id  out  $clog2(CONNECTIONS)  index of the granted cache
- grant_store  out  1  captured direction
- grant_addr  out  ADDR_WIDTH  captured address
- done  in  1  downstream transaction complete (single-cycle pulse)
- busy  out  1  arbiter is not in IDLE
- timeout_err  out  1  single-cycle pulse on watchdog abort

## Operation
- States: IDLE, ISSUE, BUSY.
- **IDLE**
  - If any req_valid is set and snoop_busy=0, select a winner with round-robin priority.
  - Search starts at (last_id+1) mod CONNECTIONS and wraps.
  - req_ready[winner] is asserted combinationally in this cycle, and only in IDLE.
  - Register winner, req_store[winner] and req_addr[winner] into grant_id/grant_store/grant_addr.
  - Move to ISSUE.
  - If snoop_busy=1 or no request is pending: stay in IDLE, req_ready=0.
- **ISSUE**
  - grant_valid=1.
  - grant_ready=1 and done=0 → BUSY.
  - grant_ready=1 and done=1 → IDLE; this counts as completion.
  - grant_ready=0 → hold; grant_* stays stable.
  - done sampled without grant_ready is ignored.
- **BUSY**
  - grant_valid=0; grant_* holds.
  - done=1 → IDLE.
  - Otherwise the watchdog increments.
  - Watchdog reaching TIMEOUT-1 with done still low → pulse timeout_err, go to IDLE.
- **Completion bookkeeping:** on completion or abort, last_id ← grant_id. The watchdog clears on entering BUSY.
- **Round-robin rules**
  - After reset, last_id = CONNECTIONS-1, so requester 0 has top priority.
  - A requester that stays asserted is granted within CONNECTIONS arbitration rounds.
- **Index handling:** req_valid bits at indices ≥ CONNECTIONS do not exist. Arithmetic on grant_id wraps modulo CONNECTIONS, not modulo 2^width.
- **Cache-side rule:** after its req_ready pulse, a cache drops req_valid or presents a new request. The arbiter takes no further action for a request whose req_valid stays asserted.
- **snoop_busy** only gates the IDLE→ISSUE decision. A transaction already in ISSUE/BUSY continues.
- **Reset mid-transaction:** state → IDLE, and the grant is discarded without a done or timeout_err. Downstream is reset together with the arbiter.

## Timing
- **Reset values:** req_ready=0, grant_valid=0, grant_id=0, grant_store=0, grant_addr=0, busy=0, timeout_err=0, watchdog=0.
- **Accept to grant:** request seen in IDLE at cycle t → req_ready pulse at t → grant_valid=1 from t+1.
- **Minimum transaction:** 2 cycles (ISSUE with grant_ready and done together).
- **After completion at cycle c:** state is IDLE at c+1, and a new request can be accepted at c+1. There is therefore one idle cycle between back-to-back transactions.
- **busy** is registered. It equals 1 in ISSUE and BUSY.
- **timeout_err** is high for exactly one cycle, the first cycle back in IDLE.
- **grant_*** change only on IDLE→ISSUE.

## Test plan
- **Reset defaults.** Hold reset 3 cycles with all req_valid=1 → all outputs 0. First grant after release: grant_id=0, req_ready=01.
- **Fairness.** CONNECTIONS=2, both requests held with addresses 0x1000/0x2000, done returned 1 cycle after grant_ready, run 6 transactions → grant_id sequence 0,1,0,1,0,1 with addresses matching.
- **Snoop block.** snoop_busy=1 for 5 cycles with req_valid=10 → no req_ready, grant_valid stays 0. snoop_busy falls at t → req_ready=10 at t, grant_id=1 at t+1.
- **Downstream backpressure.** grant_ready=0 for 4 cycles → grant_valid held, grant_addr/grant_store constant. grant_ready=1 and done=1 in the same cycle → IDLE the next cycle.
- **Watchdog.** TIMEOUT=8, done never asserted → timeout_err pulses exactly once, 8 cycles after entering BUSY. The next grant goes to the other requester.
- **Reset during BUSY.** Assert reset in BUSY → busy=0 and grant_valid=0 the next cycle, no timeout_err. Next grant is requester 0.
